// File: rtl/n29sys_6x6_core.sv
// n29sys_6x6_core
// ---------------------------------------------------------------------------
// Purpose: a 6x6 array of 36 independent AN-code (A = 29) decoder cells.
//   Each cell takes a 14-bit word that is nominally 29*N, possibly with a
//   single-bit arithmetic error (+/-2^i, i = 0..13), corrects the error and
//   registers the decoded 10-bit N. A corrected codeword that is negative
//   decodes to 0.
//
// Ports:
//   clk          rising-edge clock for all registers
//   rst          asynchronous, active-high; forces every OUTk to 0 at once
//   IN0..IN35    14-bit unsigned AN-coded input words, one per cell
//   OUT0..OUT35  10-bit unsigned decoded words, registered (latency 1)
//
// Timing: there is no handshake. Every cell samples its INk on each rising
// clk edge and presents the decode on OUTk until the next edge, so each cell
// accepts one word per cycle and the result is valid one cycle after the
// input was sampled. The output registers are the only state.
// ---------------------------------------------------------------------------
module n29sys_6x6_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [13:0] IN0,  input  logic [13:0] IN1,  input  logic [13:0] IN2,
  input  logic [13:0] IN3,  input  logic [13:0] IN4,  input  logic [13:0] IN5,
  input  logic [13:0] IN6,  input  logic [13:0] IN7,  input  logic [13:0] IN8,
  input  logic [13:0] IN9,  input  logic [13:0] IN10, input  logic [13:0] IN11,
  input  logic [13:0] IN12, input  logic [13:0] IN13, input  logic [13:0] IN14,
  input  logic [13:0] IN15, input  logic [13:0] IN16, input  logic [13:0] IN17,
  input  logic [13:0] IN18, input  logic [13:0] IN19, input  logic [13:0] IN20,
  input  logic [13:0] IN21, input  logic [13:0] IN22, input  logic [13:0] IN23,
  input  logic [13:0] IN24, input  logic [13:0] IN25, input  logic [13:0] IN26,
  input  logic [13:0] IN27, input  logic [13:0] IN28, input  logic [13:0] IN29,
  input  logic [13:0] IN30, input  logic [13:0] IN31, input  logic [13:0] IN32,
  input  logic [13:0] IN33, input  logic [13:0] IN34, input  logic [13:0] IN35,
  output logic [9:0]  OUT0,  output logic [9:0]  OUT1,  output logic [9:0]  OUT2,
  output logic [9:0]  OUT3,  output logic [9:0]  OUT4,  output logic [9:0]  OUT5,
  output logic [9:0]  OUT6,  output logic [9:0]  OUT7,  output logic [9:0]  OUT8,
  output logic [9:0]  OUT9,  output logic [9:0]  OUT10, output logic [9:0]  OUT11,
  output logic [9:0]  OUT12, output logic [9:0]  OUT13, output logic [9:0]  OUT14,
  output logic [9:0]  OUT15, output logic [9:0]  OUT16, output logic [9:0]  OUT17,
  output logic [9:0]  OUT18, output logic [9:0]  OUT19, output logic [9:0]  OUT20,
  output logic [9:0]  OUT21, output logic [9:0]  OUT22, output logic [9:0]  OUT23,
  output logic [9:0]  OUT24, output logic [9:0]  OUT25, output logic [9:0]  OUT26,
  output logic [9:0]  OUT27, output logic [9:0]  OUT28, output logic [9:0]  OUT29,
  output logic [9:0]  OUT30, output logic [9:0]  OUT31, output logic [9:0]  OUT32,
  output logic [9:0]  OUT33, output logic [9:0]  OUT34, output logic [9:0]  OUT35
);

  // Element k of these packed arrays belongs to cell k.
  logic [35:0][13:0] in_w;
  logic [35:0][9:0]  out_d;
  logic [35:0][9:0]  out_q;

  assign in_w = {IN35, IN34, IN33, IN32, IN31, IN30, IN29, IN28, IN27,
                 IN26, IN25, IN24, IN23, IN22, IN21, IN20, IN19, IN18,
                 IN17, IN16, IN15, IN14, IN13, IN12, IN11, IN10, IN9,
                 IN8,  IN7,  IN6,  IN5,  IN4,  IN3,  IN2,  IN1,  IN0};

  assign {OUT35, OUT34, OUT33, OUT32, OUT31, OUT30, OUT29, OUT28, OUT27,
          OUT26, OUT25, OUT24, OUT23, OUT22, OUT21, OUT20, OUT19, OUT18,
          OUT17, OUT16, OUT15, OUT14, OUT13, OUT12, OUT11, OUT10, OUT9,
          OUT8,  OUT7,  OUT6,  OUT5,  OUT4,  OUT3,  OUT2,  OUT1,  OUT0} = out_q;

  // One decoder cell.
  //
  // Division by 29 uses Barrett reduction: 18078 / 2^19 sits just below 1/29,
  // so q_est is exact or one short across 0..16383 and a single correction
  // step finishes the job.
  //
  // Correction: with residue r selecting error e, the corrected codeword is
  // C = x - e = 29*q + (r - e). Since r - e is always a multiple of 29, the
  // table stores delta = (r - e)/29 directly, giving C/29 = q + delta. The
  // sign of q + delta is the sign of C, which drives the clamp to 0.
  function automatic logic [9:0] decode_cell(input logic [13:0] x);
    logic [31:0]        xw;
    logic [31:0]        q_est;
    logic [31:0]        r_est;
    logic [31:0]        q;
    logic [31:0]        r;
    logic signed [31:0] delta;
    logic signed [31:0] sum;
    xw    = {18'd0, x};
    q_est = (xw * 32'd18078) >> 19;
    r_est = xw - 32'd29 * q_est;
    if (r_est >= 32'd29) begin
      r = r_est - 32'd29;
      q = q_est + 32'd1;
    end else begin
      r = r_est;
      q = q_est;
    end
    case (r)
      // e = +2^i, delta = (r - 2^i)/29
      32'd1:   delta = 32'sd0;     // i=0
      32'd2:   delta = 32'sd0;     // i=1
      32'd4:   delta = 32'sd0;     // i=2
      32'd8:   delta = 32'sd0;     // i=3
      32'd16:  delta = 32'sd0;     // i=4
      32'd3:   delta = -32'sd1;    // i=5
      32'd6:   delta = -32'sd2;    // i=6
      32'd12:  delta = -32'sd4;    // i=7
      32'd24:  delta = -32'sd8;    // i=8
      32'd19:  delta = -32'sd17;   // i=9
      32'd9:   delta = -32'sd35;   // i=10
      32'd18:  delta = -32'sd70;   // i=11
      32'd7:   delta = -32'sd141;  // i=12
      32'd14:  delta = -32'sd282;  // i=13
      // e = -2^i, delta = (r + 2^i)/29
      32'd28:  delta = 32'sd1;     // i=0
      32'd27:  delta = 32'sd1;     // i=1
      32'd25:  delta = 32'sd1;     // i=2
      32'd21:  delta = 32'sd1;     // i=3
      32'd13:  delta = 32'sd1;     // i=4
      32'd26:  delta = 32'sd2;     // i=5
      32'd23:  delta = 32'sd3;     // i=6
      32'd17:  delta = 32'sd5;     // i=7
      32'd5:   delta = 32'sd9;     // i=8
      32'd10:  delta = 32'sd18;    // i=9
      32'd20:  delta = 32'sd36;    // i=10
      32'd11:  delta = 32'sd71;    // i=11
      32'd22:  delta = 32'sd142;   // i=12
      32'd15:  delta = 32'sd283;   // i=13
      // r = 0: clean codeword, no correction
      default: delta = 32'sd0;
    endcase
    sum = $signed(q) + delta;
    if (sum < 32'sd0) begin
      return 10'd0;
    end else begin
      return sum[9:0];
    end
  endfunction

  always_comb begin
    out_d = '0;
    for (int k = 0; k < 36; k++) begin
      out_d[k] = decode_cell(in_w[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_n29sys_6x6_core.sv
// tb_n29sys_6x6_core
// Bench for n29sys_6x6_core: directed vectors with hand-computed results,
// reset checks, and a full-range sweep of every cell against a golden model
// built from exact division and a table derived from 2^i mod 29.
module tb_n29sys_6x6_core;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [13:0] in_v  [36];
  logic [9:0]  out_w [36];

  n29sys_6x6_core dut (
    .clk(clk), .rst(rst),
    .IN0(in_v[0]),   .IN1(in_v[1]),   .IN2(in_v[2]),   .IN3(in_v[3]),
    .IN4(in_v[4]),   .IN5(in_v[5]),   .IN6(in_v[6]),   .IN7(in_v[7]),
    .IN8(in_v[8]),   .IN9(in_v[9]),   .IN10(in_v[10]), .IN11(in_v[11]),
    .IN12(in_v[12]), .IN13(in_v[13]), .IN14(in_v[14]), .IN15(in_v[15]),
    .IN16(in_v[16]), .IN17(in_v[17]), .IN18(in_v[18]), .IN19(in_v[19]),
    .IN20(in_v[20]), .IN21(in_v[21]), .IN22(in_v[22]), .IN23(in_v[23]),
    .IN24(in_v[24]), .IN25(in_v[25]), .IN26(in_v[26]), .IN27(in_v[27]),
    .IN28(in_v[28]), .IN29(in_v[29]), .IN30(in_v[30]), .IN31(in_v[31]),
    .IN32(in_v[32]), .IN33(in_v[33]), .IN34(in_v[34]), .IN35(in_v[35]),
    .OUT0(out_w[0]),   .OUT1(out_w[1]),   .OUT2(out_w[2]),   .OUT3(out_w[3]),
    .OUT4(out_w[4]),   .OUT5(out_w[5]),   .OUT6(out_w[6]),   .OUT7(out_w[7]),
    .OUT8(out_w[8]),   .OUT9(out_w[9]),   .OUT10(out_w[10]), .OUT11(out_w[11]),
    .OUT12(out_w[12]), .OUT13(out_w[13]), .OUT14(out_w[14]), .OUT15(out_w[15]),
    .OUT16(out_w[16]), .OUT17(out_w[17]), .OUT18(out_w[18]), .OUT19(out_w[19]),
    .OUT20(out_w[20]), .OUT21(out_w[21]), .OUT22(out_w[22]), .OUT23(out_w[23]),
    .OUT24(out_w[24]), .OUT25(out_w[25]), .OUT26(out_w[26]), .OUT27(out_w[27]),
    .OUT28(out_w[28]), .OUT29(out_w[29]), .OUT30(out_w[30]), .OUT31(out_w[31]),
    .OUT32(out_w[32]), .OUT33(out_w[33]), .OUT34(out_w[34]), .OUT35(out_w[35])
  );

  // ---------------- scoreboard state ----------------
  logic [359:0] exp_q [$];
  string        name_q[$];
  int           tests;
  int           fails;

  // Golden decode: exact residue/quotient, error chosen by matching r against
  // 2^i mod 29 and its negation, then C = x - e with clamp.
  function automatic int golden(input int x);
    int r;
    int e;
    int p;
    int c;
    r = x % 29;
    e = 0;
    for (int i = 0; i < 14; i++) begin
      p = (1 << i) % 29;
      if (p == r) e = (1 << i);
      else if ((29 - p) == r) e = -(1 << i);
    end
    c = x - e;
    return (c < 0) ? 0 : (c / 29);
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; the next rising edge captures them,
  // so each pushed expectation is due one rising edge later.
  task automatic drive(input logic [503:0] iv, input logic [359:0] ev, input string nm);
    @(negedge clk);
    for (int k = 0; k < 36; k++) in_v[k] = iv[k*14 +: 14];
    exp_q.push_back(ev);
    name_q.push_back(nm);
  endtask

  task automatic check_zero(input string nm);
    int bad;
    bad = -1;
    tests++;
    for (int k = 0; k < 36; k++) begin
      if (out_w[k] !== 10'd0 && bad < 0) bad = k;
    end
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: OUT%0d got %0d expected 0", nm, bad, out_w[bad]);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [359:0] ev;
    string        nm;
    int           bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ev  = exp_q.pop_front();
        nm  = name_q.pop_front();
        bad = -1;
        tests++;
        for (int k = 0; k < 36; k++) begin
          if (out_w[k] !== ev[k*10 +: 10] && bad < 0) bad = k;
        end
        if (bad >= 0) begin
          fails++;
          $display("FAIL %s: OUT%0d (IN=%0d) got %0d expected %0d",
                   nm, bad, in_v[bad], out_w[bad], ev[bad*10 +: 10]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [503:0] iv;
  logic [359:0] ev;
  logic [503:0] iv_mix;
  logic [359:0] ev_mix;
  logic [13:0]  walk_vals [4];

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    for (int k = 0; k < 36; k++) in_v[k] = 14'd0;
    walk_vals[0] = 14'd1;
    walk_vals[1] = 14'd2;
    walk_vals[2] = 14'd4;
    walk_vals[3] = 14'd8192;

    // Reset with all inputs zero.
    #1;
    check_zero("reset_t0");
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    drive('0, '0, "zero_after_reset");
    drive('0, '0, "zero_after_reset");

    // Single-bit errors on a zero codeword, one input at a time.
    for (int k = 0; k < 36; k++) begin
      for (int j = 0; j < 4; j++) begin
        iv = '0;
        iv[k*14 +: 14] = walk_vals[j];
        drive(iv, '0, "walk_err_on_zero");
      end
    end

    // Mixed simultaneous stimulus, held for two cycles.
    iv_mix = '0;
    iv_mix[0*14  +: 14] = 14'd2900;
    iv_mix[7*14  +: 14] = 14'd2908;
    iv_mix[3*14  +: 14] = 14'd2896;
    iv_mix[35*14 +: 14] = 14'd16356;
    ev_mix = '0;
    ev_mix[0*10  +: 10] = 10'd100;
    ev_mix[7*10  +: 10] = 10'd100;
    ev_mix[3*10  +: 10] = 10'd100;
    ev_mix[35*10 +: 10] = 10'd564;
    drive(iv_mix, ev_mix, "mixed");
    drive(iv_mix, ev_mix, "mixed_hold");

    // Negative-correction clamp and top-of-range input.
    iv = '0;
    iv[12*14 +: 14] = 14'd3;
    iv[20*14 +: 14] = 14'd16383;
    ev = '0;
    ev[20*10 +: 10] = 10'd565;
    drive(iv, ev, "clamp_and_max");

    // Reset mid-operation, asserted between clock edges.
    drive(iv_mix, ev_mix, "mixed_before_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold_edge");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("rst_release_no_edge");
    exp_q.push_back(ev_mix);
    name_q.push_back("rst_restore");

    // Full sweep: every cell sees every value 0..16383, each at its own offset.
    for (int v = 0; v < 16384; v++) begin
      for (int k = 0; k < 36; k++) begin
        iv[k*14 +: 14] = 14'((v + k * 455) % 16384);
        ev[k*10 +: 10] = 10'(golden((v + k * 455) % 16384));
      end
      drive(iv, ev, "sweep");
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
